// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared state encoding and MIG command codes for the DDR read/write arbiter
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_WR      = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_WAIT = 3'd4
  } state_t;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr_beat_ctr.sv
// rtl/ddr_beat_ctr.sv - loadable beat counter with per-beat address generator
// done: all beats taken; done_next: done after this cycle's inc.
module ddr_beat_ctr #(
  parameter int ADDR_W    = 28,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              done,
  output logic              done_next
);

  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    addr_d = addr_q;
    if (load) begin
      cnt_d  = '0;
      len_d  = load_len;
      addr_d = load_addr;
    end else if (inc && !done) begin
      // address wraps modulo 2^ADDR_W by plain truncation
      cnt_d  = LEN_W'(cnt_q + 1'b1);
      addr_d = ADDR_W'(addr_q + ADDR_W'(ADDR_STEP));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      len_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      addr_q <= addr_d;
    end
  end

  assign addr      = addr_q;
  assign done      = (cnt_q == len_q);
  assign done_next = done || (inc && (LEN_W'(cnt_q + 1'b1) == len_q));

endmodule

// File: rtl/ddr_rw_arbiter.sv
// rtl/ddr_rw_arbiter.sv - round-robin write/read burst sequencer for the MIG DDR3 app interface
// Optional no-progress watchdog enabled by DDR_ARB_WDOG_EN.
module ddr_rw_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128,
  parameter int LEN_W       = 8,
  parameter int ADDR_STEP   = 8,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                ui_clk,
  input  logic                sys_rst_n,
  input  logic                init_calib_complete,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                wr_req,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [LEN_W-1:0]    wr_len,
  input  logic [LEN_W-1:0]    rd_len,
  output logic                wr_ack,
  output logic                rd_ack,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_data_rd,
  output logic                wr_done,
  output logic                rd_done,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_data_valid,
  output logic                err_timeout
);

  state_t      state_q, state_d;
  logic        last_rd_q, last_rd_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        in_wr, in_rd, rd_gate, gnt_wr, gnt_rd;
  logic        cmd_acc, dat_acc;
  logic [ADDR_W-1:0] wc_addr, rc_addr, unused_wd_addr, unused_rr_addr;
  logic        wc_done, wc_done_next, wd_done, wd_done_next;
  logic        rc_done, rc_done_next, rr_done_next, unused_rr_done;

  assign in_wr   = (state_q == ST_WR);
  assign in_rd   = (state_q == ST_RD);
  assign rd_gate = in_rd || (state_q == ST_RD_WAIT);
  assign gnt_wr  = wr_req && (!rd_req || last_rd_q);
  assign gnt_rd  = rd_req && !gnt_wr;

  assign app_en        = (in_wr && !wc_done) || (in_rd && !rc_done);
  assign cmd_acc       = app_en && app_rdy;
  assign app_wdf_wren  = in_wr && !wd_done;
  assign dat_acc       = app_wdf_wren && app_wdf_rdy;
  assign wr_data_rd    = dat_acc;
  assign app_wdf_end   = app_wdf_wren;
  assign app_wdf_data  = wr_data;
  assign app_wdf_mask  = '0;
  assign app_addr      = in_rd ? rc_addr : wc_addr;
  assign app_cmd       = cmd_q;
  assign rd_data       = app_rd_data;
  assign rd_data_valid = app_rd_data_valid && rd_gate;

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    cmd_d     = cmd_q;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    wr_done   = 1'b0;
    rd_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (init_calib_complete) state_d = ST_ARB;
      ST_ARB: begin
        if (init_calib_complete && gnt_wr) begin
          wr_ack    = 1'b1;
          cmd_d     = CMD_WR;
          last_rd_d = 1'b0;
          state_d   = ST_WR;
        end else if (init_calib_complete && gnt_rd) begin
          rd_ack    = 1'b1;
          cmd_d     = CMD_RD;
          last_rd_d = 1'b1;
          state_d   = ST_RD;
        end
      end
      ST_WR: begin
        if (wc_done_next && wd_done_next) begin
          wr_done = 1'b1;
          state_d = ST_ARB;
        end
      end
      ST_RD: begin
        if (rc_done_next && rr_done_next) begin
          rd_done = 1'b1;
          state_d = ST_ARB;
        end else if (rc_done_next) begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (rr_done_next) begin
          rd_done = 1'b1;
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      last_rd_q <= 1'b1;
      cmd_q     <= CMD_WR;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      cmd_q     <= cmd_d;
    end
  end

  ddr_beat_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP)) u_wr_cmd (
    .clk(ui_clk), .rst_n(sys_rst_n), .load(wr_ack), .load_addr(wr_addr), .load_len(wr_len),
    .inc(cmd_acc && in_wr), .addr(wc_addr), .done(wc_done), .done_next(wc_done_next));

  ddr_beat_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP)) u_wr_dat (
    .clk(ui_clk), .rst_n(sys_rst_n), .load(wr_ack), .load_addr(wr_addr), .load_len(wr_len),
    .inc(dat_acc), .addr(unused_wd_addr), .done(wd_done), .done_next(wd_done_next));

  ddr_beat_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP)) u_rd_cmd (
    .clk(ui_clk), .rst_n(sys_rst_n), .load(rd_ack), .load_addr(rd_addr), .load_len(rd_len),
    .inc(cmd_acc && in_rd), .addr(rc_addr), .done(rc_done), .done_next(rc_done_next));

  // return beats are counted from the first RD cycle, so early returns still count
  ddr_beat_ctr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP)) u_rd_ret (
    .clk(ui_clk), .rst_n(sys_rst_n), .load(rd_ack), .load_addr(rd_addr), .load_len(rd_len),
    .inc(rd_data_valid), .addr(unused_rr_addr), .done(unused_rr_done), .done_next(rr_done_next));

`ifdef DDR_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if (cmd_acc || dat_acc || rd_data_valid || !(in_wr || rd_gate)) begin
      wdog_d = '0;
    end else if (wdog_q != WD_W'(WDOG_CYCLES)) begin
      wdog_d = WD_W'(wdog_q + 1'b1);
    end
    if (wdog_d == WD_W'(WDOG_CYCLES)) err_d = 1'b1;
  end

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb/tb_ddr_rw_arbiter.sv - directed self-checking bench for ddr_rw_arbiter
module tb_ddr_rw_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 8;
`ifdef DDR_ARB_WDOG_EN
  localparam int WDOG = 16;
`else
  localparam int WDOG = 1024;
`endif

  logic                ui_clk = 1'b0;
  logic                sys_rst_n;
  logic                init_calib_complete;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;
  logic [DATA_W-1:0]   app_rd_data;
  logic                app_rd_data_valid;
  logic                wr_req, rd_req;
  logic [ADDR_W-1:0]   wr_addr, rd_addr;
  logic [LEN_W-1:0]    wr_len, rd_len;
  logic                wr_ack, rd_ack;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_data_rd;
  logic                wr_done, rd_done;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_data_valid;
  logic                err_timeout;

  always #5 ui_clk = ~ui_clk;

  ddr_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_STEP(8), .WDOG_CYCLES(WDOG)) dut (
    .ui_clk(ui_clk), .sys_rst_n(sys_rst_n), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .wr_req(wr_req), .rd_req(rd_req),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_len(wr_len), .rd_len(rd_len),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .wr_data(wr_data), .wr_data_rd(wr_data_rd),
    .wr_done(wr_done), .rd_done(rd_done), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .err_timeout(err_timeout));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // negedge monitor: accepted commands, pops, grants, completions
  logic [ADDR_W-1:0] cmd_addrs[$];
  int grants[$];
  int n_wpop = 0, n_wdone = 0, n_rdone = 0, n_rvalid = 0, n_en = 0, rdone_beat = 0;

  always @(negedge ui_clk) begin
    if (app_en && app_rdy) cmd_addrs.push_back(app_addr);
    if (app_en) n_en++;
    if (wr_data_rd) n_wpop++;
    if (wr_ack) grants.push_back(0);
    if (rd_ack) grants.push_back(1);
    if (wr_done) n_wdone++;
    if (rd_data_valid) n_rvalid++;
    if (rd_done) begin
      n_rdone++;
      rdone_beat = n_rvalid;
    end
  end

  task automatic cyc();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic do_req(input bit is_rd, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    if (is_rd) begin
      rd_req = 1'b1; rd_addr = a; rd_len = l;
    end else begin
      wr_req = 1'b1; wr_addr = a; wr_len = l;
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge ui_clk);
      if (is_rd ? rd_ack : wr_ack) break;
    end
    cyc();
    if (is_rd) rd_req = 1'b0; else wr_req = 1'b0;
  endtask

  task automatic wait_wdone(input int base);
    for (int i = 0; i < 100; i++) begin
      @(posedge ui_clk);
      if (n_wdone > base) break;
    end
    #1;
  endtask

  int ab, wb, pb, eb, rb, db, gb;

  initial begin
    sys_rst_n = 1'b1; init_calib_complete = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b1;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    wr_data = 128'hCAFE;
    #2 sys_rst_n = 1'b0;
    repeat (3) cyc();
    check_eq("rst_app_en", app_en, 1'b0);
    check_eq("rst_wren", app_wdf_wren, 1'b0);
    check_eq("rst_cmd", app_cmd, 3'b000);
    check_eq("rst_rdv_gated", rd_data_valid, 1'b0);
    check_eq("rst_mask", app_wdf_mask, '0);
    app_rd_data_valid = 1'b0;
    sys_rst_n = 1'b1;

    // no grant before calibration, then ack on the second cycle after calib rises
    wr_req = 1'b1; wr_addr = 28'h100; wr_len = 8'd4;
    repeat (5) cyc();
    check_eq("no_ack_precal", grants.size(), 0);
    init_calib_complete = 1'b1;
    @(negedge ui_clk);
    check_eq("ack_cycle1", wr_ack, 1'b0);
    @(negedge ui_clk);
    check_eq("ack_cycle2", wr_ack, 1'b1);
    cyc();
    wr_req = 1'b0;
    wait_wdone(0);
    check_eq("wr4_ncmd", cmd_addrs.size(), 4);
    check_eq("wr4_a0", cmd_addrs[0], 28'h100);
    check_eq("wr4_a1", cmd_addrs[1], 28'h108);
    check_eq("wr4_a2", cmd_addrs[2], 28'h110);
    check_eq("wr4_a3", cmd_addrs[3], 28'h118);
    check_eq("wr4_pops", n_wpop, 4);
    check_eq("wr4_done", n_wdone, 1);

    // address wrap
    ab = cmd_addrs.size(); wb = n_wdone;
    do_req(1'b0, 28'hFFFFFF8, 8'd2);
    wait_wdone(wb);
    check_eq("wrap_ncmd", cmd_addrs.size() - ab, 2);
    check_eq("wrap_a0", cmd_addrs[ab], 28'hFFFFFF8);
    check_eq("wrap_a1", cmd_addrs[ab+1], 28'h0000000);

    // zero-length write
    eb = n_en; wb = n_wdone; pb = n_wpop;
    do_req(1'b0, 28'h40, 8'd0);
    @(negedge ui_clk);
    check_eq("len0_done_pulse", wr_done, 1'b1);
    repeat (3) cyc();
    check_eq("len0_no_en", n_en - eb, 0);
    check_eq("len0_no_pop", n_wpop - pb, 0);
    check_eq("len0_ndone", n_wdone - wb, 1);

    // read len 3 with toggling app_rdy
    ab = cmd_addrs.size(); rb = n_rvalid; db = n_rdone;
    do_req(1'b1, 28'h200, 8'd3);
    for (int i = 0; i < 40; i++) begin
      if (cmd_addrs.size() - ab >= 3) break;
      app_rdy = ~app_rdy;
      cyc();
    end
    app_rdy = 1'b1;
    check_eq("rd_ncmd", cmd_addrs.size() - ab, 3);
    check_eq("rd_a0", cmd_addrs[ab], 28'h200);
    check_eq("rd_a1", cmd_addrs[ab+1], 28'h208);
    check_eq("rd_a2", cmd_addrs[ab+2], 28'h210);
    check_eq("rd_cmd_code", app_cmd, 3'b001);
    for (int i = 0; i < 3; i++) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = 128'hA0 + 128'(i);
      @(negedge ui_clk);
      check_eq("rd_valid", rd_data_valid, 1'b1);
      check_eq("rd_data", rd_data, 128'hA0 + 128'(i));
      check_eq("rd_done_early", rd_done, (i == 2) ? 1'b1 : 1'b0);
      cyc();
    end
    @(negedge ui_clk);
    check_eq("late_ret_gated", rd_data_valid, 1'b0);
    app_rd_data_valid = 1'b0;
    check_eq("rd_ndone", n_rdone - db, 1);
    check_eq("rd_done_beat", rdone_beat - rb, 3);

    // tie alternation from reset: WR, RD, WR
    cyc();
    sys_rst_n = 1'b0;
    cyc();
    sys_rst_n = 1'b1;
    gb = grants.size();
    wr_addr = 28'h500; wr_len = 8'd1; rd_addr = 28'h600; rd_len = 8'd0;
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (grants.size() - gb >= 3) break;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    repeat (6) cyc();
    check_eq("alt_ngrants", grants.size() - gb, 3);
    check_eq("alt_g0", grants[gb], 0);
    check_eq("alt_g1", grants[gb+1], 1);
    check_eq("alt_g2", grants[gb+2], 0);

    // reset mid-burst aborts
    app_rdy = 1'b0;
    do_req(1'b0, 28'h300, 8'd4);
    @(negedge ui_clk);
    check_eq("stall_en", app_en, 1'b1);
    #1 sys_rst_n = 1'b0;
    #1;
    check_eq("abort_en", app_en, 1'b0);
    check_eq("abort_wren", app_wdf_wren, 1'b0);
    cyc();
    sys_rst_n = 1'b1;
    app_rdy = 1'b1;

`ifdef DDR_ARB_WDOG_EN
    app_rdy = 1'b0;
    do_req(1'b1, 28'h700, 8'd1);
    repeat (16) @(negedge ui_clk);
    check_eq("wdog_pre", err_timeout, 1'b0);
    @(negedge ui_clk);
    check_eq("wdog_set", err_timeout, 1'b1);
    repeat (10) cyc();
    check_eq("wdog_sticky", err_timeout, 1'b1);
    sys_rst_n = 1'b0;
    cyc();
    sys_rst_n = 1'b1;
    app_rdy = 1'b1;
`else
    check_eq("err_tied0", err_timeout, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
